// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt sequencer between the M stage and CP0: turns a CP0 entry request
// or an M-stage eret into a one-cycle kill/flush/redirect step, with debug event counters.
module exc_seq_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_NONE   = 5'd0,
    parameter logic [15:0] CNT_MAX    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  exc_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic        eret_d,
    input  logic        mtc0_epc_e,
    input  logic        mtc0_epc_m,
    input  logic        cp0_req,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_vpc,
    output logic        cp0_bd,
    output logic        cp0_exlclr,
    output logic        kill_m,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        stall_d,
    output logic [1:0]  state,
    output logic [15:0] entry_cnt,
    output logic [15:0] eret_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t st, nxt;
    logic   entry_evt, eret_evt;

    // req has priority over eret; neither is sampled outside RUN
    assign entry_evt = (st == RUN) && cp0_req;
    assign eret_evt  = (st == RUN) && !cp0_req && eret_m;

    always_ff @(posedge clk) begin
        if (reset) st <= RUN;
        else       st <= nxt;
    end

    always_comb begin
        nxt         = st;
        kill_m      = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = HANDLER_PC;
        cp0_exlclr  = 1'b0;
        cp0_exccode = EXC_NONE;
        cp0_bd      = 1'b0;
        stall_d     = 1'b0;
        case (st)
            RUN: begin
                // M-stage info only reaches CP0 in RUN so it is never latched twice
                cp0_exccode = exc_m;
                cp0_bd      = bd_m;
                stall_d     = eret_d && (mtc0_epc_e || mtc0_epc_m);
                if (cp0_req) begin
                    kill_m = 1'b1;
                    nxt    = ENTER;
                end else if (eret_m) begin
                    kill_m = 1'b1;
                    nxt    = RETURN;
                end
            end
            ENTER: begin
                kill_m      = 1'b1;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = HANDLER_PC;
                nxt         = RUN;
            end
            RETURN: begin
                cp0_exlclr  = 1'b1;
                kill_m      = 1'b1;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = cp0_epc;
                nxt         = RUN;
            end
            default: nxt = RUN;
        endcase
    end

    // saturating debug counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_cnt <= '0;
            eret_cnt  <= '0;
        end else begin
            if (entry_evt && entry_cnt != CNT_MAX) entry_cnt <= entry_cnt + 16'd1;
            if (eret_evt && eret_cnt != CNT_MAX)   eret_cnt  <= eret_cnt + 16'd1;
        end
    end

    assign cp0_vpc = pc_m;
    assign state   = st;

endmodule
